// File: rtl/stopwatch_btn_ctrl.sv
// Pushbutton front end for the stopwatch counter: synchronizes and debounces the
// run and clear buttons and turns their presses into run_stop / clear commands.
module stopwatch_btn_ctrl #(
  parameter int DEBOUNCE_CNT = 100_000,
  parameter int CLEAR_CYC    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_clear,
  output logic       run_stop,
  output logic       clear,
  output logic [1:0] state_led
);

  localparam int CNT_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam int HOLD_W = (CLEAR_CYC > 1) ? $clog2(CLEAR_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLEAR_CYC - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_e;

  // Bit 0 carries the run button, bit 1 the clear button.
  logic [1:0]       btn_vec;
  logic [1:0]       meta_q, sync_q;
  logic [1:0]       deb_q, deb_d, deb_dly_q;
  logic [1:0]       press_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  logic             press_run, press_clear;
  state_e           state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  assign btn_vec = {btn_clear, btn_run};

  // NOTE: every flop, including each debounce counter in the array, is cleared by
  // the async reset so that no half-finished debounce survives a reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q    <= '0;
      sync_q    <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      press_q   <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage sample the previous
      // stage's old value, which is what builds the two-flop synchronizer chain.
      meta_q    <= btn_vec;
      sync_q    <= meta_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      press_q   <= deb_q & ~deb_dly_q;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A change is accepted only after it has been stable for DEBOUNCE_CNT cycles;
  // any return to the accepted level restarts the count.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    deb_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = sync_q[i];
        else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign press_run   = press_q[0];
  assign press_clear = press_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STOP;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Clear is only honoured while stopped and wins over a simultaneous run press.
  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    case (state_q)
      ST_STOP: begin
        if (press_clear)    state_d = ST_CLEAR;
        else if (press_run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (press_run) state_d = ST_STOP;
      end
      ST_CLEAR: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_LAST) begin
          state_d = ST_STOP;
          hold_d  = '0;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_comb begin
    run_stop  = (state_q == ST_RUN);
    clear     = (state_q == ST_CLEAR);
    state_led = state_q;
  end

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Bench for stopwatch_btn_ctrl: stimulus tasks push expected state changes into a
// scoreboard; a negedge monitor pops them on their due cycle and checks outputs.
module tb_stopwatch_btn_ctrl;

  localparam int DEB = 4;
  localparam int CLR = 4;
  localparam int LAT = 2 + DEB + 1 + 1;

  localparam logic [1:0] ST_STOP  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_CLEAR = 2'b10;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       btn_run   = 1'b0;
  logic       btn_clear = 1'b0;
  logic       run_stop;
  logic       clear;
  logic [1:0] state_led;

  typedef struct {
    int         cyc;
    logic [1:0] st;
  } ev_t;

  ev_t        sb[$];
  int         cyc    = 0;
  int         n_chk  = 0;
  int         n_pass = 0;
  bit         mon_en = 1'b0;
  logic [1:0] mon_st = ST_STOP;
  logic [1:0] exp_st = ST_STOP;

  stopwatch_btn_ctrl #(.DEBOUNCE_CNT(DEB), .CLEAR_CYC(CLR)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_run   (btn_run),
    .btn_clear (btn_clear),
    .run_stop  (run_stop),
    .clear     (clear),
    .state_led (state_led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Expected outputs follow the scoreboard; reset discards anything pending.
  always @(negedge clk) begin
    logic [1:0] st;
    ev_t        ev;
    if (mon_en) begin
      st = mon_st;
      if (!reset) begin
        sb.delete();
        st = ST_STOP;
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        ev = sb.pop_front();
        check($sformatf("ev_due@%0d", cyc), cyc, ev.cyc);
        st = ev.st;
      end
      check($sformatf("outs@%0d", cyc), int'({state_led, run_stop, clear}),
            int'({st, st == ST_RUN, st == ST_CLEAR}));
      mon_st <= st;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Records the state changes a clean press starting on cycle k must cause.
  task automatic expect_press(input int k, input bit run, input bit clr);
    ev_t ev;
    if (exp_st == ST_STOP) begin
      if (clr) begin
        ev.cyc = k + LAT;       ev.st = ST_CLEAR; sb.push_back(ev);
        ev.cyc = k + LAT + CLR; ev.st = ST_STOP;  sb.push_back(ev);
      end else if (run) begin
        ev.cyc = k + LAT; ev.st = ST_RUN; sb.push_back(ev);
        exp_st = ST_RUN;
      end
    end else if (exp_st == ST_RUN && run) begin
      ev.cyc = k + LAT; ev.st = ST_STOP; sb.push_back(ev);
      exp_st = ST_STOP;
    end
  endtask

  task automatic press(input bit run, input bit clr);
    expect_press(cyc, run, clr);
    btn_run   = run;
    btn_clear = clr;
    tick(20);
    btn_run   = 1'b0;
    btn_clear = 1'b0;
    tick(14);
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    check("rst_outs", int'({state_led, run_stop, clear}), 0);
    mon_en = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(50);

    // Clean run toggle, held for 20 cycles each time.
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);

    // Bouncing run press: only the final stable level counts.
    btn_run = 1'b1; tick(1);
    btn_run = 1'b0; tick(1);
    btn_run = 1'b1; tick(1);
    btn_run = 1'b0; tick(1);
    expect_press(cyc, 1'b1, 1'b0);
    btn_run = 1'b1; tick(20);
    btn_run = 1'b0; tick(14);
    press(1'b1, 1'b0);

    // Clear from STOP, clear ignored in RUN, simultaneous presses.
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);

    // Reset during the second cycle of CLEAR.
    expect_press(cyc, 1'b0, 1'b1);
    btn_clear = 1'b1;
    tick(LAT + 1);
    reset = 1'b0;
    #1;
    check("midrst_clear", int'(clear), 0);
    check("midrst_led", int'(state_led), int'(ST_STOP));
    btn_clear = 1'b0;
    tick(2);
    reset  = 1'b1;
    exp_st = ST_STOP;
    tick(30);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
